// File: rtl/cdma_ll_sched.sv
// rtl/cdma_ll_sched.sv - linked-list descriptor scheduler for the CDMA channel
// Fetches 6-word descriptors, issues one copy per descriptor, follows next_ptr until end/abort/error.
`timescale 1ns/1ps
module cdma_ll_sched #(
    parameter int DESC_WORDS = 6,
    parameter int TO_W       = 12,
    parameter int MAX_DESC   = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] head_ptr_i,
    input  logic        abort_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [1:0]  status_o,
    output logic [15:0] desc_cnt_o,
    output logic        irq_o,
    output logic        ll_req_o,
    output logic [31:0] ll_addr_o,
    input  logic        ll_ack_i,
    input  logic        ll_dvld_i,
    input  logic [31:0] ll_rdata_i,
    output logic        xfer_req_o,
    output logic [31:0] xfer_src_o,
    output logic [31:0] xfer_dst_o,
    output logic [15:0] xfer_len_o,
    input  logic        xfer_ack_i,
    input  logic        xfer_done_i
);
    localparam int              CW      = $clog2(DESC_WORDS);
    localparam logic [CW-1:0]   LAST_W  = CW'(DESC_WORDS - 1);
    // Firing one count early lands done exactly 2**TO_W-1 cycles after the last dvld.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((1 << TO_W) - 3);
    localparam logic [15:0]     MAX_CNT = 16'(MAX_DESC);
    localparam logic [1:0] ST_OK = 2'b00, ST_ABORT = 2'b01, ST_TMO = 2'b10, ST_BAD = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_REQ, S_FETCH_DATA, S_XFER_REQ, S_XFER_WAIT, S_FIN
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     ptr_q, ptr_d;
    logic [CW-1:0]   word_cnt_q, word_cnt_d;
    logic [31:0]     src_q, src_d, dst_q, dst_d, next_q, next_d;
    logic [16:0]     w2_q, w2_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            abort_pend_q, abort_pend_d;
    logic [1:0]      status_q, status_d;
    logic [15:0]     desc_cnt_q, desc_cnt_d;
    logic            irq_q, irq_d;
    logic            abort_now;
    logic [15:0]     cnt_inc;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            word_cnt_q   <= '0;
            src_q        <= '0;
            dst_q        <= '0;
            next_q       <= '0;
            w2_q         <= '0;
            to_cnt_q     <= '0;
            abort_pend_q <= 1'b0;
            status_q     <= '0;
            desc_cnt_q   <= '0;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            word_cnt_q   <= word_cnt_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            next_q       <= next_d;
            w2_q         <= w2_d;
            to_cnt_q     <= to_cnt_d;
            abort_pend_q <= abort_pend_d;
            status_q     <= status_d;
            desc_cnt_q   <= desc_cnt_d;
            irq_q        <= irq_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        word_cnt_d   = word_cnt_q;
        src_d        = src_q;
        dst_d        = dst_q;
        next_d       = next_q;
        w2_d         = w2_q;
        to_cnt_d     = to_cnt_q;
        abort_pend_d = abort_pend_q;
        status_d     = status_q;
        desc_cnt_d   = desc_cnt_q;
        irq_d        = 1'b0;
        abort_now    = abort_i | abort_pend_q;
        cnt_inc      = (desc_cnt_q == 16'hFFFF) ? desc_cnt_q : desc_cnt_q + 16'd1;

        if (state_q != S_IDLE && abort_i) begin
            abort_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d      = S_FETCH_REQ;
                    ptr_d        = head_ptr_i;
                    abort_pend_d = 1'b0;
                    desc_cnt_d   = '0;
                    status_d     = ST_OK;
                end
            end
            S_FETCH_REQ: begin
                if (ll_ack_i) begin
                    state_d    = S_FETCH_DATA;
                    word_cnt_d = '0;
                    to_cnt_d   = '0;
                end else if (abort_now) begin
                    state_d  = S_FIN;
                    status_d = ST_ABORT;
                end
            end
            S_FETCH_DATA: begin
                if (ll_dvld_i) begin
                    to_cnt_d   = '0;
                    word_cnt_d = word_cnt_q + CW'(1);
                    case (word_cnt_q)
                        CW'(0):  src_d  = ll_rdata_i;
                        CW'(1):  dst_d  = ll_rdata_i;
                        CW'(2):  w2_d   = ll_rdata_i[16:0];
                        CW'(3):  next_d = ll_rdata_i;
                        default: ;
                    endcase
                    // An abort during the read still drains the words already in flight.
                    if (word_cnt_q == LAST_W) begin
                        if (abort_now) begin
                            state_d  = S_FIN;
                            status_d = ST_ABORT;
                        end else begin
                            state_d = S_XFER_REQ;
                        end
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    state_d  = S_FIN;
                    status_d = ST_TMO;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            S_XFER_REQ: begin
                if (xfer_ack_i) begin
                    state_d = S_XFER_WAIT;
                end
            end
            S_XFER_WAIT: begin
                if (xfer_done_i) begin
                    desc_cnt_d = cnt_inc;
                    irq_d      = w2_q[16];
                    if (abort_now) begin
                        state_d  = S_FIN;
                        status_d = ST_ABORT;
                    end else if (next_q == 32'd0) begin
                        state_d  = S_FIN;
                        status_d = ST_OK;
                    end else if (next_q[1:0] != 2'b00 || cnt_inc >= MAX_CNT) begin
                        state_d  = S_FIN;
                        status_d = ST_BAD;
                    end else begin
                        state_d = S_FETCH_REQ;
                        ptr_d   = next_q;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_FIN);
    assign status_o   = status_q;
    assign desc_cnt_o = desc_cnt_q;
    assign irq_o      = irq_q;
    assign ll_req_o   = (state_q == S_FETCH_REQ);
    assign ll_addr_o  = ptr_q & 32'hFFFF_FFFC;
    assign xfer_req_o = (state_q == S_XFER_REQ);
    assign xfer_src_o = src_q;
    assign xfer_dst_o = dst_q;
    assign xfer_len_o = w2_q[15:0];
endmodule

// File: tb/tb_cdma_ll_sched.sv
// tb/tb_cdma_ll_sched.sv - scoreboard bench for cdma_ll_sched
// Memory and copy-engine responders; expected fetches, transfers and completions are queued ahead.
`timescale 1ns/1ps
module tb_cdma_ll_sched;
    localparam int MAX_DESC = 1024;

    logic        clk, rst, start, abort_i;
    logic [31:0] head_ptr;
    logic        busy_o, done_o, irq_o, ll_req_o, xfer_req_o;
    logic [1:0]  status_o;
    logic [15:0] desc_cnt_o, xfer_len_o;
    logic [31:0] ll_addr_o, xfer_src_o, xfer_dst_o;
    logic        ll_ack, ll_dvld, xfer_ack, xfer_done;
    logic [31:0] ll_rdata;

    cdma_ll_sched dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .head_ptr_i(head_ptr), .abort_i(abort_i),
        .busy_o(busy_o), .done_o(done_o), .status_o(status_o), .desc_cnt_o(desc_cnt_o),
        .irq_o(irq_o), .ll_req_o(ll_req_o), .ll_addr_o(ll_addr_o), .ll_ack_i(ll_ack),
        .ll_dvld_i(ll_dvld), .ll_rdata_i(ll_rdata), .xfer_req_o(xfer_req_o),
        .xfer_src_o(xfer_src_o), .xfer_dst_o(xfer_dst_o), .xfer_len_o(xfer_len_o),
        .xfer_ack_i(xfer_ack), .xfer_done_i(xfer_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0, n_errors = 0;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_addr[$];
    logic [79:0] exp_xfer[$];
    logic        exp_irq[$];
    logic [17:0] exp_done[$];

    int  fetch_words = 6;
    bit  abort_w3 = 0, abort_on_done = 0;
    bit  done_seen = 0, busy_chk = 0, irq_pend_v = 0, irq_pend = 0;
    int  dvld_cnt = 0, last_dvld_cyc = 0, done_cyc = 0, done_dvld = 0;

    function automatic logic [31:0] rd(input logic [31:0] a, input int w);
        logic [31:0] ad;
        ad = (a & 32'hFFFF_FFFC) + 32'(4 * w);
        return mem.exists(ad) ? mem[ad] : (32'hDEAD_0000 ^ ad);
    endfunction

    task automatic put_desc(input logic [31:0] a, input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] len, input logic ie, input logic [31:0] nxt);
        mem[a] = s; mem[a + 4] = d; mem[a + 8] = {15'h5A5A, ie, len}; mem[a + 12] = nxt;
    endtask

    // Reference walk of a chain in memory, following the descriptor rules directly.
    task automatic push_chain(input logic [31:0] head);
        logic [31:0] p, nxt, w2;
        int n;
        p = head; n = 0;
        forever begin
            w2 = rd(p, 2);
            exp_addr.push_back(p & 32'hFFFF_FFFC);
            exp_xfer.push_back({rd(p, 0), rd(p, 1), w2[15:0]});
            exp_irq.push_back(w2[16]);
            n++;
            nxt = rd(p, 3);
            if (nxt == 0) begin exp_done.push_back({2'b00, 16'(n)}); break; end
            if (nxt[1:0] != 0 || n >= MAX_DESC) begin exp_done.push_back({2'b11, 16'(n)}); break; end
            p = nxt;
        end
    endtask

    // Memory responder: ack, then six words with one gap, optional abort on the 4th word.
    initial begin
        logic [31:0] fa;
        ll_ack = 0; ll_dvld = 0; ll_rdata = 0;
        forever begin
            @(posedge clk); #1;
            if (ll_req_o) begin
                fa = ll_addr_o;
                ll_ack = 1;
                @(posedge clk); #1;
                ll_ack = 0;
                for (int w = 0; w < fetch_words; w++) begin
                    if (w == 2) begin @(posedge clk); #1; end
                    ll_dvld = 1; ll_rdata = rd(fa, w);
                    if (w == 3 && abort_w3) abort_i = 1;
                    @(posedge clk); #1;
                    ll_dvld = 0;
                    if (abort_w3) abort_i = 0;
                end
            end
        end
    end

    initial begin
        xfer_ack = 0; xfer_done = 0;
        forever begin
            @(posedge clk); #1;
            if (xfer_req_o) begin
                xfer_ack = 1;
                @(posedge clk); #1;
                xfer_ack = 0;
                repeat (2) @(posedge clk);
                #1;
                xfer_done = 1;
                if (abort_on_done) abort_i = 1;
                @(posedge clk); #1;
                xfer_done = 0;
                if (abort_on_done) abort_i = 0;
            end
        end
    end

    initial begin
        logic [79:0] ex;
        logic [17:0] ed;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (irq_pend_v) begin check("irq", irq_o, irq_pend); irq_pend_v = 0; end
                else if (irq_o) check("irq_stray", irq_o, 0);
                if (busy_chk) begin check("busy_after_done", busy_o, 0); busy_chk = 0; end
                if (ll_dvld) begin dvld_cnt++; last_dvld_cyc = cyc; end
                if (ll_req_o && ll_ack) begin
                    if (exp_addr.size() == 0) check("ll_req_unexp", 1, 0);
                    else check("ll_addr", ll_addr_o, exp_addr.pop_front());
                end
                if (xfer_req_o && xfer_ack) begin
                    if (exp_xfer.size() == 0) check("xfer_req_unexp", 1, 0);
                    else begin
                        ex = exp_xfer.pop_front();
                        check("xfer_src", xfer_src_o, ex[79:48]);
                        check("xfer_dst", xfer_dst_o, ex[47:16]);
                        check("xfer_len", xfer_len_o, ex[15:0]);
                    end
                end
                if (xfer_done && exp_irq.size() != 0) begin
                    irq_pend = exp_irq.pop_front(); irq_pend_v = 1;
                end
                if (done_o) begin
                    done_seen = 1; busy_chk = 1; done_cyc = cyc; done_dvld = dvld_cnt;
                    check("busy_at_done", busy_o, 1);
                    if (exp_done.size() == 0) check("done_unexp", 1, 0);
                    else begin
                        ed = exp_done.pop_front();
                        check("status", status_o, ed[17:16]);
                        check("desc_cnt", desc_cnt_o, ed[15:0]);
                    end
                end
            end
        end
    end

    task automatic start_chain(input logic [31:0] h);
        done_seen = 0; dvld_cnt = 0;
        @(posedge clk); #1;
        start = 1; head_ptr = h;
        @(posedge clk); #1;
        start = 0;
        check("busy_start", busy_o, 1);
        check("ll_req_start", ll_req_o, 1);
    endtask

    task automatic wait_done(input int budget);
        int i;
        i = 0;
        while (!done_seen && i < budget) begin @(negedge clk); i++; end
        check("done_seen", done_seen, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic sb_empty();
        check("sb_addr_left", exp_addr.size(), 0);
        check("sb_xfer_left", exp_xfer.size(), 0);
        check("sb_done_left", exp_done.size(), 0);
    endtask

    initial begin
        rst = 1; start = 0; head_ptr = 0; abort_i = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_busy", busy_o, 0);       check("rst_done", done_o, 0);
        check("rst_status", status_o, 0);   check("rst_desc_cnt", desc_cnt_o, 0);
        check("rst_irq", irq_o, 0);         check("rst_ll_req", ll_req_o, 0);
        check("rst_ll_addr", ll_addr_o, 0); check("rst_xfer_req", xfer_req_o, 0);
        check("rst_src", xfer_src_o, 0);    check("rst_dst", xfer_dst_o, 0);
        check("rst_len", xfer_len_o, 0);

        // single descriptor
        put_desc(32'h1000, 32'h2000, 32'h3000, 16'h00FF, 1'b0, 32'h0);
        push_chain(32'h1000);
        start_chain(32'h1000);
        wait_done(200);
        sb_empty();

        // two descriptors, irq on the second
        put_desc(32'h1000, 32'h2100, 32'h3100, 16'h0010, 1'b0, 32'h1040);
        put_desc(32'h1040, 32'h2200, 32'h3200, 16'h1234, 1'b1, 32'h0);
        push_chain(32'h1000);
        start_chain(32'h1003);
        wait_done(400);
        sb_empty();

        // abort after the 3rd word: drain, no transfer
        abort_w3 = 1;
        exp_addr.push_back(32'h1000);
        exp_done.push_back({2'b01, 16'd0});
        start_chain(32'h1000);
        wait_done(200);
        abort_w3 = 0;
        check("abort_drain_words", done_dvld, 6);
        check("abort_done_lat", done_cyc - last_dvld_cyc, 1);
        sb_empty();

        // abort coincident with xfer_done of the first of two
        abort_on_done = 1;
        exp_addr.push_back(32'h1000);
        exp_xfer.push_back({32'h2100, 32'h3100, 16'h0010});
        exp_irq.push_back(1'b0);
        exp_done.push_back({2'b01, 16'd1});
        start_chain(32'h1000);
        wait_done(400);
        abort_on_done = 0;
        sb_empty();

        // fetch timeout after two words
        fetch_words = 2;
        exp_addr.push_back(32'h1040);
        exp_done.push_back({2'b10, 16'd0});
        start_chain(32'h1040);
        wait_done(5000);
        fetch_words = 6;
        check("timeout_cycles", done_cyc - last_dvld_cyc, 4095);
        sb_empty();

        // misaligned next pointer
        put_desc(32'h1000, 32'h2000, 32'h3000, 16'h0001, 1'b0, 32'h1042);
        push_chain(32'h1000);
        start_chain(32'h1000);
        wait_done(400);
        sb_empty();

        // chain of MAX_DESC+1 descriptors hits the loop guard
        for (int i = 0; i <= MAX_DESC; i++) begin
            put_desc(32'h10000 + 32'(i * 32), 32'h8000_0000 + 32'(i), 32'h9000_0000 + 32'(i),
                     16'(i), 1'b0, (i == MAX_DESC) ? 32'h0 : 32'h10000 + 32'((i + 1) * 32));
        end
        push_chain(32'h10000);
        start_chain(32'h10000);
        wait_done(40000);
        sb_empty();

        // reset mid-fetch, stray words follow
        put_desc(32'h1000, 32'h2000, 32'h3000, 16'h00FF, 1'b0, 32'h0);
        exp_addr.push_back(32'h1000);
        start_chain(32'h1000);
        for (int i = 0; i < 100 && dvld_cnt < 2; i++) @(negedge clk);
        @(posedge clk); #1 rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        exp_addr.delete(); exp_xfer.delete(); exp_irq.delete(); exp_done.delete();
        repeat (10) @(negedge clk);
        check("rr_busy", busy_o, 0);      check("rr_ll_req", ll_req_o, 0);
        check("rr_xfer_req", xfer_req_o, 0); check("rr_done_seen", done_seen, 0);
        check("rr_desc_cnt", desc_cnt_o, 0); check("rr_src", xfer_src_o, 0);
        push_chain(32'h1000);
        start_chain(32'h1000);
        wait_done(200);
        sb_empty();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
